// File: rtl/egress_port_arbiter_if.sv
// egress_port_arbiter_if: ingress-queue and egress-FIFO signals of one egress port.
// master = arbiter side, slave = queue/FIFO side.
`timescale 1ns/1ps
interface egress_port_arbiter_if #(
  parameter int unsigned NUM_IN = 4
);
  logic [NUM_IN-1:0]   req;
  logic [8*NUM_IN-1:0] in_data;
  logic [NUM_IN-1:0]   in_last;
  logic [NUM_IN-1:0]   in_empty;
  logic [NUM_IN-1:0]   pop;
  logic                out_full;
  logic [7:0]          out_data;
  logic                out_wr;
  logic                out_done;
  logic [NUM_IN-1:0]   grant;
  logic                busy;

  modport master (
    input  req, in_data, in_last, in_empty, out_full,
    output pop, out_data, out_wr, out_done, grant, busy
  );

  modport slave (
    output req, in_data, in_last, in_empty, out_full,
    input  pop, out_data, out_wr, out_done, grant, busy
  );
endinterface

// File: rtl/egress_port_arbiter.sv
// egress_port_arbiter: frame-granular round-robin arbiter for one egress port.
// Define ARB_TIMEOUT_EN to enable the starvation timeout (runt byte + release).
`timescale 1ns/1ps
module egress_port_arbiter #(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned IFG_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  egress_port_arbiter_if.master bus
);
  localparam int unsigned PTR_W = $clog2(NUM_IN);
  localparam int unsigned IDX_W = PTR_W + 1;
  localparam int unsigned GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  if (NUM_IN < 2 || NUM_IN > 8 || TIMEOUT == 0) begin : g_cfg_check
    $error("egress_port_arbiter: NUM_IN must be 2..8 and TIMEOUT nonzero");
  end

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [NUM_IN-1:0] r_grant, w_grant_nxt;
  logic [PTR_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [PTR_W-1:0]  r_owner, w_owner_nxt;
  logic [GAP_W-1:0]  r_gap_cnt, w_gap_cnt_nxt;
  logic [7:0]        r_out_data, w_out_data_nxt;
  logic              r_out_wr, w_out_wr_nxt;
  logic              r_out_done, w_out_done_nxt;

  logic [NUM_IN-1:0] w_pop;
  logic              w_pop_any;
  logic              w_timeout;
  logic [7:0]        w_head;
  logic              w_head_last;
  logic              w_found;
  logic [PTR_W-1:0]  w_sel;
  logic [IDX_W-1:0]  w_idx;

  // Pop is gated by reset so an aborted frame loses no extra byte.
  assign w_pop       = (r_state == XFER && !reset && !bus.out_full) ? (r_grant & ~bus.in_empty) : '0;
  assign w_pop_any   = |w_pop;
  assign w_head      = bus.in_data[8*r_owner +: 8];
  assign w_head_last = bus.in_last[r_owner];

  // Round-robin scan starting at r_rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      w_idx = {1'b0, r_rr_ptr} + IDX_W'(k);
      if (w_idx >= IDX_W'(NUM_IN)) begin
        w_idx = w_idx - IDX_W'(NUM_IN);
      end
      if (!w_found && bus.req[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[PTR_W-1:0];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_wait;

  assign w_to_wait = (r_state == XFER) && bus.in_empty[r_owner] && !bus.out_full;
  assign w_timeout = w_to_wait && (r_to_cnt == TO_W'(TIMEOUT - 1));

  // Starvation counter: cleared by pops, frozen by out_full.
  always_ff @(posedge clk) begin
    if (reset || r_state != XFER || w_pop_any) begin
      r_to_cnt <= '0;
    end else if (w_to_wait) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_out_data_nxt = r_out_data;
    w_out_wr_nxt   = 1'b0;
    w_out_done_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nxt        = '0;
          w_grant_nxt[w_sel] = 1'b1;
          w_owner_nxt        = w_sel;
          w_state_nxt        = XFER;
        end
      end
      XFER: begin
        if (w_pop_any || w_timeout) begin
          w_out_wr_nxt   = 1'b1;
          w_out_data_nxt = w_pop_any ? w_head : 8'h00;
          w_out_done_nxt = w_pop_any ? w_head_last : 1'b1;
          if (!w_pop_any || w_head_last) begin
            w_grant_nxt   = '0;
            w_rr_ptr_nxt  = (r_owner == PTR_W'(NUM_IN - 1)) ? '0 : r_owner + 1'b1;
            w_gap_cnt_nxt = '0;
            w_state_nxt   = (IFG_CYCLES == 0) ? IDLE : GAP;
          end
        end
      end
      GAP: begin
        if (r_gap_cnt == GAP_W'(IFG_CYCLES - 1)) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_gap_cnt  <= '0;
      r_out_data <= '0;
      r_out_wr   <= 1'b0;
      r_out_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_out_data <= w_out_data_nxt;
      r_out_wr   <= w_out_wr_nxt;
      r_out_done <= w_out_done_nxt;
    end
  end

  assign bus.pop      = w_pop;
  assign bus.grant    = r_grant;
  assign bus.busy     = (r_state != IDLE);
  assign bus.out_data = r_out_data;
  assign bus.out_wr   = r_out_wr;
  assign bus.out_done = r_out_done;
endmodule

// File: tb/tb_egress_port_arbiter.sv
// tb_egress_port_arbiter: directed bench for egress_port_arbiter (NUM_IN=4, IFG=2, TIMEOUT=8).
`timescale 1ns/1ps
module tb_egress_port_arbiter;
  localparam int unsigned N = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  egress_port_arbiter_if #(.NUM_IN(N)) bus ();

  egress_port_arbiter #(.NUM_IN(N), .IFG_CYCLES(2), .TIMEOUT(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // FWFT ingress queue model
  logic [7:0]  qmem [N][64];
  logic        qlst [N][64];
  int unsigned qwr [N];
  int unsigned qav [N];
  int unsigned qrd [N];
  logic [N-1:0] req_en = '0;
  logic [N-1:0] flush  = '0;
  int unsigned  cyc    = 0;

  always_comb begin
    bus.in_data  = '0;
    bus.in_last  = '0;
    bus.in_empty = '0;
    bus.req      = '0;
    for (int i = 0; i < N; i++) begin
      bus.in_data[8*i +: 8] = qmem[i][qrd[i] % 64];
      bus.in_last[i]        = qlst[i][qrd[i] % 64];
      bus.in_empty[i]       = (qrd[i] >= qav[i]);
      bus.req[i]            = req_en[i] && (qrd[i] < qwr[i]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (flush[i]) qrd[i] <= qwr[i];
      else if (bus.pop[i]) qrd[i] <= qrd[i] + 1;
    end
    cyc <= cyc + 1;
  end

  // Egress-side log
  logic [7:0]   wr_data [$];
  logic         wr_done [$];
  int unsigned  wr_cyc  [$];
  logic [N-1:0] gr_log  [$];
  logic [N-1:0] prev_grant = '0;
  int unsigned  bad_done = 0;
  int unsigned  bad_pop  = 0;

  always @(negedge clk) begin
    if (bus.out_wr === 1'b1) begin
      wr_data.push_back(bus.out_data);
      wr_done.push_back(bus.out_done);
      wr_cyc.push_back(cyc);
    end
    if (bus.out_done === 1'b1 && bus.out_wr !== 1'b1) bad_done <= bad_done + 1;
    if ((bus.pop & ~bus.grant) != '0) bad_pop <= bad_pop + 1;
    if (bus.grant != prev_grant && bus.grant != '0) gr_log.push_back(bus.grant);
    prev_grant <= bus.grant;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input int q, input int len, input logic [7:0] base, input int hold);
    for (int j = 0; j < len; j++) begin
      qmem[q][qwr[q] % 64] = base + 8'(j);
      qlst[q][qwr[q] % 64] = (j == len - 1);
      qwr[q]++;
    end
    qav[q] = qwr[q] - hold;
  endtask

  task automatic wait_grant(output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      tick();
      if (bus.grant != '0) ok = 1'b1;
    end
  endtask

  task automatic wait_quiet(output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      tick();
      if (bus.busy === 1'b0 && bus.req == '0 && bus.out_wr === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic ok;
    for (int q = 0; q < N; q++) load_frame(q, 1, 8'hA0 + 8'(q), 0);
    req_en = '1;
    reset  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({bus.grant, bus.pop, bus.out_data, bus.out_wr, bus.out_done, bus.busy} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs c%0d: grant=%b pop=%b data=%h wr=%b done=%b busy=%b, want all 0",
                 c, bus.grant, bus.pop, bus.out_data, bus.out_wr, bus.out_done, bus.busy);
      end
    end
    reset = 1'b0;
    wait_grant(ok);
    n_checks++;
    if (bus.grant !== 4'b0001) begin
      n_fail++; $display("FAIL reset_first_grant: got %b want 0001", bus.grant);
    end
    wait_quiet(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL reset_drain: got timeout want idle"); end
  endtask

  task automatic test_round_robin();
    logic ok;
    int unsigned s, g;
    s = wr_data.size();
    g = gr_log.size();
    for (int q = 0; q < N; q++) load_frame(q, 3, 8'(16 * (q + 1)), 0);
    wait_quiet(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL rr_drain: got timeout want idle"); end
    n_checks++;
    if (gr_log.size() - g !== 4) begin
      n_fail++; $display("FAIL rr_grant_count: got %0d want 4", gr_log.size() - g);
    end
    for (int k = 0; k < 4; k++) begin
      if (g + k < gr_log.size()) begin
        n_checks++;
        if (gr_log[g + k] !== 4'(1 << k)) begin
          n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, gr_log[g + k], 4'(1 << k));
        end
      end
    end
    n_checks++;
    if (wr_data.size() - s !== 12) begin
      n_fail++; $display("FAIL rr_wr_count: got %0d want 12", wr_data.size() - s);
    end
    for (int k = 0; k < 12; k++) begin
      if (s + k < wr_data.size()) begin
        n_checks++;
        if ({wr_data[s + k], wr_done[s + k]} !== {8'(16 * (k / 3 + 1) + k % 3), (k % 3 == 2)}) begin
          n_fail++;
          $display("FAIL rr_byte%0d: got data=%h done=%b want data=%h done=%b", k,
                   wr_data[s + k], wr_done[s + k], 8'(16 * (k / 3 + 1) + k % 3), (k % 3 == 2));
        end
      end
    end
    for (int k = 1; k < 12; k++) begin
      if (s + k < wr_cyc.size()) begin
        n_checks++;
        if (wr_cyc[s + k] - wr_cyc[s + k - 1] !== ((k % 3 == 0) ? 4 : 1)) begin
          n_fail++;
          $display("FAIL rr_spacing%0d: got %0d want %0d", k,
                   wr_cyc[s + k] - wr_cyc[s + k - 1], (k % 3 == 0) ? 4 : 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    int unsigned s;
    s = wr_data.size();
    load_frame(0, 6, 8'h60, 0);
    wait_grant(ok);
    n_checks++;
    if (bus.pop !== 4'b0001) begin n_fail++; $display("FAIL bp_first_pop: got %b want 0001", bus.pop); end
    tick();
    bus.out_full = 1'b1;
    #1;
    n_checks++;
    if ({bus.pop, bus.out_wr, bus.out_data} !== {4'b0000, 1'b1, 8'h60}) begin
      n_fail++;
      $display("FAIL bp_stall0: got pop=%b wr=%b data=%h want pop=0000 wr=1 data=60",
               bus.pop, bus.out_wr, bus.out_data);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({bus.pop, bus.out_wr} !== 5'b0) begin
        n_fail++; $display("FAIL bp_stall%0d: got pop=%b wr=%b want 0000/0", c + 1, bus.pop, bus.out_wr);
      end
    end
    bus.out_full = 1'b0;
    wait_quiet(ok);
    n_checks++;
    if (wr_data.size() - s !== 6) begin
      n_fail++; $display("FAIL bp_wr_count: got %0d want 6", wr_data.size() - s);
    end
    for (int k = 0; k < 6; k++) begin
      if (s + k < wr_data.size()) begin
        n_checks++;
        if ({wr_data[s + k], wr_done[s + k]} !== {8'h60 + 8'(k), (k == 5)}) begin
          n_fail++;
          $display("FAIL bp_byte%0d: got data=%h done=%b want data=%h done=%b", k,
                   wr_data[s + k], wr_done[s + k], 8'h60 + 8'(k), (k == 5));
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic ok;
    int unsigned s, g;
    req_en = 4'b0100;
    g = gr_log.size();
    load_frame(2, 2, 8'h40, 0);
    wait_quiet(ok);
    n_checks++;
    if (gr_log.size() <= g || gr_log[g] !== 4'b0100) begin
      n_fail++; $display("FAIL wrap_setup_grant: got %b want 0100", (gr_log.size() > g) ? gr_log[g] : 4'b0);
    end
    s = wr_data.size();
    g = gr_log.size();
    req_en = 4'b0101;
    load_frame(0, 2, 8'h70, 0);
    load_frame(2, 2, 8'h80, 0);
    wait_quiet(ok);
    n_checks++;
    if (gr_log.size() - g !== 2) begin
      n_fail++; $display("FAIL wrap_grant_count: got %0d want 2", gr_log.size() - g);
    end else begin
      n_checks++;
      if ({gr_log[g], gr_log[g + 1]} !== {4'b0001, 4'b0100}) begin
        n_fail++; $display("FAIL wrap_order: got %b,%b want 0001,0100", gr_log[g], gr_log[g + 1]);
      end
    end
    n_checks++;
    if (wr_data.size() - s !== 4 ||
        {wr_data[s], wr_data[s + 1], wr_data[s + 2], wr_data[s + 3]} !== 32'h70718081) begin
      n_fail++; $display("FAIL wrap_data: got %0d bytes want 70 71 80 81", wr_data.size() - s);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic ok;
    int unsigned s, g, dones;
    req_en = 4'b0010;
    s = wr_data.size();
    load_frame(1, 5, 8'h50, 0);
    wait_grant(ok);
    n_checks++;
    if (bus.grant !== 4'b0010) begin n_fail++; $display("FAIL mid_grant: got %b want 0010", bus.grant); end
    tick();
    tick();
    reset  = 1'b1;
    flush  = 4'b0010;
    req_en = '0;
    #1;
    n_checks++;
    if (bus.pop !== 4'b0000) begin n_fail++; $display("FAIL mid_pop_in_reset: got %b want 0000", bus.pop); end
    tick();
    reset = 1'b0;
    flush = '0;
    n_checks++;
    if ({bus.grant, bus.out_wr, bus.out_done, bus.busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL mid_after_reset: got grant=%b wr=%b done=%b busy=%b want 0",
               bus.grant, bus.out_wr, bus.out_done, bus.busy);
    end
    repeat (3) tick();
    dones = 0;
    for (int unsigned k = s; k < wr_done.size(); k++) if (wr_done[k] === 1'b1) dones++;
    n_checks++;
    if (wr_data.size() - s !== 2 || dones !== 0) begin
      n_fail++; $display("FAIL mid_abandon: got %0d writes %0d dones want 2 writes 0 dones",
                         wr_data.size() - s, dones);
    end
    g = gr_log.size();
    req_en = 4'b1010;
    load_frame(1, 1, 8'h91, 0);
    load_frame(3, 1, 8'h93, 0);
    wait_quiet(ok);
    n_checks++;
    if (gr_log.size() - g !== 2 || gr_log[g] !== 4'b0010) begin
      n_fail++; $display("FAIL mid_rr_cleared: got first grant %b want 0010",
                         (gr_log.size() > g) ? gr_log[g] : 4'b0);
    end
  endtask

  task automatic test_timeout();
    logic ok;
    int unsigned s;
    req_en = 4'b0001;
    s = wr_data.size();
    load_frame(0, 3, 8'hC0, 2);
`ifdef ARB_TIMEOUT_EN
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      tick();
      if (bus.out_wr === 1'b1 && bus.out_done === 1'b1) ok = 1'b1;
    end
    flush  = 4'b0001;
    req_en = '0;
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL to_fire: got no runt write want runt write"); end
    n_checks++;
    if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL to_release: got %b want 0000", bus.grant); end
    tick();
    flush = '0;
    wait_quiet(ok);
    n_checks++;
    if (wr_data.size() - s !== 2) begin
      n_fail++; $display("FAIL to_wr_count: got %0d want 2", wr_data.size() - s);
    end else begin
      n_checks++;
      if ({wr_data[s], wr_done[s], wr_data[s + 1], wr_done[s + 1]} !== {8'hC0, 1'b0, 8'h00, 1'b1}) begin
        n_fail++;
        $display("FAIL to_bytes: got %h/%b %h/%b want c0/0 00/1",
                 wr_data[s], wr_done[s], wr_data[s + 1], wr_done[s + 1]);
      end
      n_checks++;
      if (wr_cyc[s + 1] - wr_cyc[s] !== 8) begin
        n_fail++; $display("FAIL to_delay: got %0d want 8", wr_cyc[s + 1] - wr_cyc[s]);
      end
    end
`else
    repeat (30) tick();
    n_checks++;
    if ({bus.grant, bus.busy} !== {4'b0001, 1'b1} || wr_data.size() - s !== 1) begin
      n_fail++; $display("FAIL wait_hold: got grant=%b busy=%b writes=%0d want 0001/1/1",
                         bus.grant, bus.busy, wr_data.size() - s);
    end
    qav[0] = qwr[0];
    wait_quiet(ok);
    n_checks++;
    if (wr_data.size() - s !== 3 || {wr_data[s + 2], wr_done[s + 2]} !== {8'hC2, 1'b1}) begin
      n_fail++; $display("FAIL wait_resume: got %0d writes want 3 ending c2/done", wr_data.size() - s);
    end
`endif
  endtask

  task automatic test_invariants();
    n_checks++;
    if (bad_done !== 0) begin n_fail++; $display("FAIL done_without_wr: got %0d want 0", bad_done); end
    n_checks++;
    if (bad_pop !== 0) begin n_fail++; $display("FAIL pop_outside_grant: got %0d want 0", bad_pop); end
  endtask

  initial begin
    bus.out_full = 1'b0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid_frame();
    test_timeout();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog");
  end
endmodule
